// File: rtl/piramide_seq.sv
`default_nettype none
// ============================================================================
// Module   : piramide_seq
// Brief    : Plays an amplitude table on the 4-bit triangle generator, each
//            entry for a programmed number of full periods.
// Revision : 1.0 - initial release
// ============================================================================
module piramide_seq #(
    parameter  int DEPTH  = 4,
    parameter  int REP_W  = 4,
    parameter  int PERIOD = 30,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [3:0]       cfg_max,
    input  logic [REP_W-1:0] cfg_rep,
    input  logic [AW:0]      n_entries,
    input  logic             start,
    input  logic             abort,
    output logic             gen_rst,
    output logic [3:0]       gen_max,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [AW-1:0]    entry_idx,
    output logic             period_tick
);

    localparam logic [4:0] c_PHASE_LAST = 5'(PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [3:0]       r_tbl_max [DEPTH];
    logic [REP_W-1:0] r_tbl_rep [DEPTH];
    logic [AW:0]      r_n;
    logic [AW-1:0]    r_idx;
    logic [REP_W-1:0] r_rep;
    logic [4:0]       r_phase;
    logic             r_aborted;
    logic             r_zero_done;

    logic [AW:0]      w_last_idx;
    logic             w_is_last;
    logic             w_period_end;

    assign w_last_idx   = r_n - 1'b1;
    assign w_is_last    = ({1'b0, r_idx} == w_last_idx);
    assign w_period_end = (r_phase == c_PHASE_LAST);

    // All outputs are pure decodes of registered state.
    assign gen_rst     = (r_state != S_RUN);
    assign busy        = (r_state == S_PRIME) || (r_state == S_RUN);
    assign gen_max     = busy ? r_tbl_max[r_idx] : 4'h0;
    assign done        = (r_state == S_DONE) || r_zero_done;
    assign aborted     = r_aborted;
    assign entry_idx   = r_idx;
    assign period_tick = (r_state == S_RUN) && w_period_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_idx       <= '0;
            r_rep       <= '0;
            r_phase     <= '0;
            r_aborted   <= 1'b0;
            r_zero_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl_max[i] <= 4'hF;
                r_tbl_rep[i] <= '0;
            end
        end else begin
            r_zero_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_we) begin
                        r_tbl_max[cfg_addr] <= cfg_max;
                        r_tbl_rep[cfg_addr] <= cfg_rep;
                    end
                    if (start) begin
                        r_aborted <= 1'b0;
                        if (n_entries != '0) begin
                            r_state <= S_PRIME;
                            r_n     <= n_entries;
                            r_idx   <= '0;
                            r_rep   <= '0;
                        end else begin
                            r_zero_done <= 1'b1;
                        end
                    end
                end
                S_PRIME: begin
                    if (abort) begin
                        r_state   <= S_DONE;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                        r_phase <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state   <= S_DONE;
                        r_aborted <= 1'b1;
                    end else if (w_period_end) begin
                        r_phase <= '0;
                        if (r_rep < r_tbl_rep[r_idx]) begin
                            r_rep <= r_rep + 1'b1;
                        end else if (w_is_last) begin
                            r_state <= S_DONE;
                        end else begin
                            // Generator is back at 0 here, so no re-prime needed.
                            r_idx <= r_idx + 1'b1;
                            r_rep <= '0;
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piramide_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_piramide_seq
// Brief    : Scoreboard bench for piramide_seq; directed sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piramide_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [3:0] cfg_max = '0;
    logic [3:0] cfg_rep = '0;
    logic [2:0] n_entries = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       gen_rst;
    logic [3:0] gen_max;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [1:0] entry_idx;
    logic       period_tick;

    piramide_seq #(.DEPTH(4), .REP_W(4), .PERIOD(30)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_max(cfg_max), .cfg_rep(cfg_rep), .n_entries(n_entries),
        .start(start), .abort(abort), .gen_rst(gen_rst), .gen_max(gen_max),
        .busy(busy), .done(done), .aborted(aborted), .entry_idx(entry_idx),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; logic [1:0] idx; logic [3:0] mx;} tick_t;
    typedef struct {int c; logic ab; logic [1:0] idx;} done_t;
    tick_t tick_q[$];
    done_t done_q[$];
    tick_t t_exp;
    done_t d_exp;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT emits a tick or done.
    always @(negedge clk) begin
        if (!rst) begin
            if (period_tick) begin
                if (tick_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_tick: got tick expected none (cycle %0d)", cyc);
                end else begin
                    t_exp = tick_q.pop_front();
                    check("tick_cycle", cyc, t_exp.c);
                    check("tick_idx", entry_idx, t_exp.idx);
                    check("tick_gen_max", gen_max, t_exp.mx);
                    check("tick_busy", busy, 1);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
                end else begin
                    d_exp = done_q.pop_front();
                    check("done_cycle", cyc, d_exp.c);
                    check("done_aborted", aborted, d_exp.ab);
                    check("done_idx", entry_idx, d_exp.idx);
                    check("done_busy", busy, 0);
                    check("done_gen_rst", gen_rst, 1);
                    check("done_gen_max", gen_max, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [3:0] mx, input logic [3:0] rp);
        cfg_we = 1'b1; cfg_addr = a; cfg_max = mx; cfg_rep = rp;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic begin_seq(input logic [2:0] n, output int s);
        s = cyc;
        start = 1'b1; n_entries = n;
        tick();
        start = 1'b0;
    endtask

    task automatic push_tick(input int c, input logic [1:0] idx, input logic [3:0] mx);
        tick_t e;
        e.c = c; e.idx = idx; e.mx = mx;
        tick_q.push_back(e);
    endtask

    task automatic push_done(input int c, input logic ab, input logic [1:0] idx);
        done_t e;
        e.c = c; e.ab = ab; e.idx = idx;
        done_q.push_back(e);
    endtask

    initial begin
        int s;
        tick(); tick(); tick();
        check("rst_gen_rst", gen_rst, 1);
        check("rst_gen_max", gen_max, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_entry_idx", entry_idx, 0);
        check("rst_period_tick", period_tick, 0);
        rst = 1'b0;
        tick();

        // Single entry, amplitude 8, one period.
        write_entry(2'd0, 4'd8, 4'd0);
        begin_seq(3'd1, s);
        push_tick(s + 31, 2'd0, 4'd8);
        push_done(s + 32, 1'b0, 2'd0);
        check("t1_prime_busy", busy, 1);
        check("t1_prime_gen_rst", gen_rst, 1);
        check("t1_prime_gen_max", gen_max, 8);
        wait_cyc(s + 2);
        check("t1_run_gen_rst", gen_rst, 0);
        wait_cyc(s + 33);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_gen_rst", gen_rst, 1);

        // Abort while idle must not produce done.
        abort = 1'b1; tick(); abort = 1'b0;
        tick(); tick();

        // Two entries: {5,1} then {15,0}.
        write_entry(2'd0, 4'd5, 4'd1);
        write_entry(2'd1, 4'd15, 4'd0);
        begin_seq(3'd2, s);
        push_tick(s + 31, 2'd0, 4'd5);
        push_tick(s + 61, 2'd0, 4'd5);
        push_tick(s + 91, 2'd1, 4'd15);
        push_done(s + 92, 1'b0, 2'd1);
        wait_cyc(s + 32);
        check("t2_rep_idx", entry_idx, 0);
        check("t2_rep_gen_max", gen_max, 5);
        wait_cyc(s + 62);
        check("t2_e1_idx", entry_idx, 1);
        check("t2_e1_gen_max", gen_max, 15);
        wait_cyc(s + 94);
        check("t2_hold_idx", entry_idx, 1);

        // Abort at RUN phase 10.
        begin_seq(3'd1, s);
        wait_cyc(s + 12);
        push_done(s + 13, 1'b1, 2'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        wait_cyc(s + 15);
        check("t3_aborted_hold", aborted, 1);
        check("t3_busy", busy, 0);

        // Zero-entry start.
        begin_seq(3'd0, s);
        push_done(s + 1, 1'b0, 2'd0);
        check("t4_busy0", busy, 0);
        check("t4_aborted_clr", aborted, 0);
        tick();
        check("t4_busy1", busy, 0);
        tick();

        // Write and start while busy are ignored; read back via a second run.
        begin_seq(3'd1, s);
        push_tick(s + 31, 2'd0, 4'd5);
        push_tick(s + 61, 2'd0, 4'd5);
        push_done(s + 62, 1'b0, 2'd0);
        wait_cyc(s + 5);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_max = 4'd3; cfg_rep = 4'd0;
        start = 1'b1; n_entries = 3'd2;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        wait_cyc(s + 64);
        begin_seq(3'd1, s);
        push_tick(s + 31, 2'd0, 4'd5);
        push_tick(s + 61, 2'd0, 4'd5);
        push_done(s + 62, 1'b0, 2'd0);
        wait_cyc(s + 64);

        // Reset mid-run while entry 1 plays; table returns to defaults.
        begin_seq(3'd2, s);
        push_tick(s + 31, 2'd0, 4'd5);
        push_tick(s + 61, 2'd0, 4'd5);
        wait_cyc(s + 70);
        check("t6_pre_idx", entry_idx, 1);
        rst = 1'b1; tick();
        check("t6_gen_rst", gen_rst, 1);
        check("t6_gen_max", gen_max, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_idx", entry_idx, 0);
        check("t6_tick", period_tick, 0);
        rst = 1'b0; tick();
        begin_seq(3'd2, s);
        push_tick(s + 31, 2'd0, 4'd15);
        push_tick(s + 61, 2'd1, 4'd15);
        push_done(s + 62, 1'b0, 2'd1);
        wait_cyc(s + 64);

        check("tick_q_empty", tick_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
